// File: rtl/blk_126658.sv
// WIDTH-bit, STAGES-deep posedge pipeline register with per-stage valid bits, stall, flush and occupancy.
// Optional per-stage parity tracking is built when FIREBIRD7_IN_GATE2_PIPE_PARITY_EN is defined.
module blk_126658 #(
    parameter int               WIDTH       = 8,
    parameter int               STAGES      = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter int               OCC_W       = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
`ifdef FIREBIRD7_IN_GATE2_PIPE_PARITY_EN
    input  logic             par_inj,
    output logic             parity_err,
`endif
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0]  stage      [STAGES];
    logic [WIDTH-1:0]  stage_next [STAGES];
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] vld_next;
    logic [OCC_W-1:0]  occ_next;
    logic              load;

    // Flush wins over enable: the word presented alongside a flush is dropped.
    assign load = en & ~flush;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        stage_next    = stage;
        vld_next      = vld;
        stage_next[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_next[i] = stage[i-1];
        end
        if (flush) begin
            vld_next = '0;
        end else if (en) begin
            vld_next[0] = d_valid;
            for (int i = 1; i < STAGES; i++) begin
                vld_next[i] = vld[i-1];
            end
        end
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_next = occ_next + OCC_W'(vld_next[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data stages are explicitly reset because q must show RESET_VALUE after reset.
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= RESET_VALUE;
            end
            vld <= '0;
            occ <= '0;
        end else begin
            vld <= vld_next;
            occ <= occ_next;
            if (load) begin
                stage <= stage_next;
            end
        end
    end

    assign q       = stage[STAGES-1];
    assign q_valid = vld[STAGES-1];

`ifdef FIREBIRD7_IN_GATE2_PIPE_PARITY_EN
    logic [STAGES-1:0] par;
    logic [STAGES-1:0] par_next;

    always_comb begin
        par_next[0] = (^d) ^ par_inj;
        for (int i = 1; i < STAGES; i++) begin
            par_next[i] = par[i-1];
        end
    end

    // Checked against the incoming last-stage contents so the error lines up with q.
    always_ff @(posedge clk) begin
        if (rst) begin
            par        <= {STAGES{^RESET_VALUE}};
            parity_err <= 1'b0;
        end else if (flush) begin
            parity_err <= 1'b0;
        end else if (en) begin
            par        <= par_next;
            parity_err <= vld_next[STAGES-1] &
                          ((^stage_next[STAGES-1]) != par_next[STAGES-1]);
        end
    end
`endif

endmodule

// File: tb/tb_blk_126658.sv
// Directed self-checking bench for blk_126658 (WIDTH=8, STAGES=3, RESET_VALUE=8'hA5).
module tb_blk_126658;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;
    localparam int OCC_W  = $clog2(STAGES + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_valid;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic [OCC_W-1:0] occ;
`ifdef FIREBIRD7_IN_GATE2_PIPE_PARITY_EN
    logic             par_inj;
    logic             parity_err;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    blk_126658 #(
        .WIDTH       (WIDTH),
        .STAGES      (STAGES),
        .RESET_VALUE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .flush      (flush),
        .d          (d),
        .d_valid    (d_valid),
`ifdef FIREBIRD7_IN_GATE2_PIPE_PARITY_EN
        .par_inj    (par_inj),
        .parity_err (parity_err),
`endif
        .q          (q),
        .q_valid    (q_valid),
        .occ        (occ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one set of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic r, input logic e, input logic f,
                       input logic [WIDTH-1:0] dd, input logic dv);
        rst     = r;
        en      = e;
        flush   = f;
        d       = dd;
        d_valid = dv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] bub_d  [6];
        logic       bub_v  [6];
        logic       bub_qv [6];
        logic [7:0] bub_q  [6];
        logic [1:0] bub_oc [6];
        bub_d  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        bub_v  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bub_qv = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        bub_q  = '{8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40};
        bub_oc = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};

`ifdef FIREBIRD7_IN_GATE2_PIPE_PARITY_EN
        par_inj = 1'b0;
`endif
        rst = 1'b1; en = 1'b1; flush = 1'b0; d = 8'hFF; d_valid = 1'b1;

        // Reset with valid data presented.
        cyc(1, 1, 0, 8'hFF, 1);
        cyc(1, 1, 0, 8'hFF, 1);
        check("rst_q", q, 8'hA5);
        check("rst_qv", q_valid, 0);
        check("rst_occ", occ, 0);

        // Streaming: first word reaches q on the 3rd enabled edge.
        cyc(0, 1, 0, 8'h01, 1);
        check("s1_occ", occ, 1);
        check("s1_qv", q_valid, 0);
        cyc(0, 1, 0, 8'h02, 1);
        check("s2_occ", occ, 2);
        check("s2_qv", q_valid, 0);
        cyc(0, 1, 0, 8'h03, 1);
        check("s3_q", q, 8'h01);
        check("s3_qv", q_valid, 1);
        check("s3_occ", occ, 3);
        cyc(0, 1, 0, 8'h04, 1);
        check("s4_q", q, 8'h02);
        check("s4_occ_full", occ, 3);
        cyc(0, 1, 0, 8'h05, 1);
        check("s5_q", q, 8'h03);
        check("s5_occ_full", occ, 3);

        // Stall with 8'h11 in stage 1.
        cyc(0, 1, 0, 8'h11, 1);
        check("st_pre_q", q, 8'h04);
        cyc(0, 1, 0, 8'h12, 1);
        check("st_load_q", q, 8'h05);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 8'hEE, 1);
            check("st_hold_q", q, 8'h05);
            check("st_hold_qv", q_valid, 1);
            check("st_hold_occ", occ, 3);
        end
        cyc(0, 1, 0, 8'h13, 1);
        check("st_exit_q", q, 8'h11);
        check("st_exit_qv", q_valid, 1);

        // Flush collides with a valid enabled word.
        cyc(0, 1, 1, 8'h77, 1);
        check("fl_qv", q_valid, 0);
        check("fl_occ", occ, 0);
        check("fl_q_hold", q, 8'h11);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 8'h00, 0);
            check("fl_drain_qv", q_valid, 0);
            check("fl_drain_occ", occ, 0);
        end

        // Bubbles: alternating valid/invalid input.
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, bub_d[i], bub_v[i]);
            check("bub_qv", q_valid, bub_qv[i]);
            check("bub_occ", occ, bub_oc[i]);
            if (bub_qv[i]) check("bub_q", q, bub_q[i]);
        end
        cyc(0, 1, 0, 8'h00, 0);
        check("drain_q", q, 8'h50);
        check("drain_occ", occ, 1);
        cyc(0, 1, 0, 8'h00, 0);
        check("empty_occ", occ, 0);
        cyc(0, 1, 0, 8'h00, 0);
        check("empty_stay_occ", occ, 0);

        // Reset mid-stream drops in-flight words.
        cyc(0, 1, 0, 8'h21, 1);
        cyc(0, 1, 0, 8'h22, 1);
        cyc(1, 1, 0, 8'h23, 1);
        check("mrst_q", q, 8'hA5);
        check("mrst_qv", q_valid, 0);
        check("mrst_occ", occ, 0);
        cyc(0, 1, 0, 8'h00, 0);
        cyc(0, 1, 0, 8'h00, 0);
        check("mrst_after_qv", q_valid, 0);

`ifdef FIREBIRD7_IN_GATE2_PIPE_PARITY_EN
        cyc(1, 1, 0, 8'h00, 0);
        check("par_rst", parity_err, 0);
        par_inj = 1'b1;
        cyc(0, 1, 0, 8'h3C, 1);
        par_inj = 1'b0;
        check("par_e1", parity_err, 0);
        cyc(0, 1, 0, 8'h01, 1);
        check("par_e2", parity_err, 0);
        cyc(0, 1, 0, 8'h02, 1);
        check("par_q3c", q, 8'h3C);
        check("par_err_set", parity_err, 1);
        cyc(0, 1, 0, 8'h03, 1);
        check("par_clean", parity_err, 0);
        par_inj = 1'b1;
        cyc(0, 1, 0, 8'h3C, 1);
        par_inj = 1'b0;
        cyc(0, 1, 0, 8'h00, 1);
        cyc(0, 1, 0, 8'h00, 1);
        check("par_err_set2", parity_err, 1);
        cyc(1, 1, 0, 8'h00, 0);
        check("par_rst_clear", parity_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
